// File: rtl/npc_unit_if.sv
// Next-PC unit bus: controller/regfile side drives, npc_unit serves.
// Optional exception ports are present when NPC_EXC_EN is defined.
interface npc_unit_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic              stall;
  logic [2:0]        br_type;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [15:0]       imm16;
  logic [25:0]       instr_index;
  logic              j;
  logic              jal;
  logic              jr;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] link_addr;
  logic [1:0]        pc_op;
  logic              ras_hit;
  logic [CW-1:0]     ras_cnt;
`ifdef NPC_EXC_EN
  logic              exc_req;
  logic              eret;
  logic [ADDR_W-1:0] epc;
`endif

  modport master (
    output stall, br_type, rs_val, rt_val,
    output imm16, instr_index, j, jal, jr,
`ifdef NPC_EXC_EN
    output exc_req, eret,
    input  epc,
`endif
    input  pc, pc_plus4, link_addr,
    input  pc_op, ras_hit, ras_cnt
  );

  modport slave (
    input  stall, br_type, rs_val, rt_val,
    input  imm16, instr_index, j, jal, jr,
`ifdef NPC_EXC_EN
    input  exc_req, eret,
    output epc,
`endif
    output pc, pc_plus4, link_addr,
    output pc_op, ras_hit, ras_cnt
  );
endinterface

// File: rtl/npc_unit.sv
// Next-PC unit: PC register, branch/jump/jr resolution, stall and RAS.
// Define NPC_EXC_EN to add exc_req/eret redirection and an epc register.
module npc_unit #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          RAS_DEPTH = 4,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
  input logic   clk,
  input logic   reset,
  npc_unit_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] jr_tgt;
  logic [ADDR_W-1:0] next_pc;
  logic [1:0]        pc_op;
  logic              taken;
  logic              hold;
  logic              sel_br;
  logic              sel_j;
  logic              sel_jr;
  logic              push;
  logic              pop;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     top_idx;
  logic [CW-1:0]     cnt;

  logic signed [DATA_W-1:0] rs_s;
  logic signed [DATA_W-1:0] rt_s;

  assign rs_s = bus.rs_val;
  assign rt_s = bus.rt_val;

  assign pc_plus4 = pc + ADDR_W'(4);
  assign br_tgt   = pc_plus4
                  + {{(ADDR_W-18){bus.imm16[15]}}, bus.imm16, 2'b00};
  assign j_tgt    = {pc_plus4[ADDR_W-1:28], bus.instr_index, 2'b00};
  assign jr_tgt   = bus.rs_val[ADDR_W-1:0];

  always_comb begin
    taken = 1'b0;
    unique case (bus.br_type)
      3'b001:  taken = (rs_s == rt_s);
      3'b010:  taken = (rs_s != rt_s);
      3'b011:  taken = (rs_s <= 0);
      3'b100:  taken = (rs_s > 0);
      3'b101:  taken = (rs_s < 0);
      3'b110:  taken = (rs_s >= 0);
      default: taken = 1'b0;
    endcase
  end

`ifdef NPC_EXC_EN
  logic [ADDR_W-1:0] epc;
  assign hold = bus.exc_req | bus.eret;
`else
  logic unused_exc;
  assign hold       = 1'b0;
  assign unused_exc = ^EXC_VEC;
`endif

  // One-hot selects encode the priority so the decoder below is unique.
  assign sel_br = !hold && taken;
  assign sel_j  = !hold && !taken && (bus.j || bus.jal);
  assign sel_jr = !hold && !taken && !bus.j && !bus.jal && bus.jr;

  always_comb begin
    pc_op   = 2'b00;
    next_pc = pc_plus4;
    unique case (1'b1)
      sel_br: begin
        pc_op   = 2'b01;
        next_pc = br_tgt;
      end
      sel_j: begin
        pc_op   = 2'b10;
        next_pc = j_tgt;
      end
      sel_jr: begin
        pc_op   = 2'b11;
        next_pc = jr_tgt;
      end
      default: begin
        pc_op   = 2'b00;
        next_pc = pc_plus4;
      end
    endcase
`ifdef NPC_EXC_EN
    if (bus.exc_req)
      next_pc = ADDR_W'(EXC_VEC);
    else if (bus.eret)
      next_pc = epc;
`endif
  end

  assign top_idx = ptr - PW'(1);
  assign push    = sel_j && bus.jal;
  assign pop     = sel_jr && (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= ADDR_W'(RESET_PC);
      ptr <= '0;
      cnt <= '0;
    end else if (!bus.stall) begin
      pc <= next_pc;
      if (push) begin
        ptr <= ptr + PW'(1);
        if (cnt != CW'(RAS_DEPTH))
          cnt <= cnt + CW'(1);
      end else if (pop) begin
        ptr <= top_idx;
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Entries are left as-is on reset; ras_cnt alone marks validity.
  always_ff @(posedge clk) begin
    if (!reset && !bus.stall && push)
      ras_mem[ptr] <= pc_plus4;
  end

`ifdef NPC_EXC_EN
  always_ff @(posedge clk) begin
    if (reset)
      epc <= '0;
    else if (!bus.stall && bus.exc_req)
      epc <= pc;
  end
  assign bus.epc = epc;
`endif

  assign bus.pc        = pc;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.link_addr = pc_plus4;
  assign bus.pc_op     = pc_op;
  assign bus.ras_cnt   = cnt;
  assign bus.ras_hit   = (pc_op == 2'b11) && (cnt != '0)
                      && (ras_mem[top_idx] == jr_tgt);
endmodule

// File: doc/npc_unit.md
Name: npc_unit

Overview:
- Parametrised next-PC unit for the MIPS datapath.
- Owns the PC register and resolves branch condition, branch target and jump target internally.
- Adds a stall hold and a return-address stack (RAS) that checks jr targets against the addresses pushed by jal.
- Sits between the controller/register file and instruction memory; pc drives IM address each cycle.

Parameters:
- ADDR_W, 32, PC width; legal range 29..32.
- DATA_W, 32, width of rs_val/rt_val.
- RESET_PC, 32'h0000_3000, PC value after reset (truncated to ADDR_W).
- RAS_DEPTH, 4, RAS entries; power of two, 2..16.
- EXC_VEC, 32'h0000_4180, exception handler address (used only with NPC_EXC_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous reset, active high.
- stall  in  1  hold PC and RAS this cycle.
- br_type  in  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 none.
- rs_val  in  DATA_W  GPR[rs]; branch operand and jr target.
- rt_val  in  DATA_W  GPR[rt]; beq/bne operand.
- imm16  in  16  branch offset (words).
- instr_index  in  26  j/jal target field.
- j  in  1  jump.
- jal  in  1  jump and link.
- jr  in  1  jump register.
- pc  out  ADDR_W  current PC (registered).
- pc_plus4  out  ADDR_W  pc+4, combinational.
- link_addr  out  ADDR_W  equals pc_plus4; written to $31 by the datapath.
- pc_op  out  2  selected source: 00 seq, 01 branch, 10 j/jal, 11 jr (combinational).
- ras_hit  out  1  jr executing, RAS non-empty and top == rs_val[ADDR_W-1:0] (combinational).
- ras_cnt  out  $clog2(RAS_DEPTH)+1  valid RAS entries (registered).

Behaviour:
- Reset (synchronous, overrides stall): pc<=RESET_PC, ras_cnt<=0, RAS pointer<=0. RAS entries are not cleared. Reset asserted mid-stall or mid-sequence still takes effect on that edge.
- Branch condition, signed compare on DATA_W:
  - beq: rs==rt; bne: rs!=rt.
  - blez: rs<=0; bgtz: rs>0; bltz: rs<0; bgez: rs>=0.
  - br_type 000 or 111: never taken.
- Targets:
  - branch = pc_plus4 + (sign_ext(imm16)<<2), modulo 2^ADDR_W.
  - jump = {pc_plus4[ADDR_W-1:28], instr_index, 2'b00}.
  - jr = rs_val[ADDR_W-1:0], used as is with no alignment fix.
- Priority: taken branch (01) > j or jal (10) > jr (11) > seq (00).
- Update: each clock with !reset && !stall, pc<=target selected by pc_op. When stall=1, pc, RAS and ras_cnt hold and nothing is pushed or popped.
- RAS, updated only on a non-stalled edge:
  - Push: pc_op==10 && jal. Entry[ptr]<=link_addr; ptr<=ptr+1 mod RAS_DEPTH; ras_cnt saturates at RAS_DEPTH. On overflow the oldest entry is silently overwritten.
  - Pop: pc_op==11. ptr<=ptr-1 and ras_cnt-1 when ras_cnt>0. Pop on empty leaves ptr and ras_cnt unchanged and ras_hit=0.
  - A pop occurs regardless of ras_hit; the PC always follows rs_val.
  - Simultaneous jal+jr: jal wins, push only. Taken branch with jal/jr asserted: no push, no pop.
- ras_hit compares against the entry at ptr-1 before the edge.
- Latency: target is visible on pc one cycle after inputs are presented; pc_op, pc_plus4 and ras_hit are same-cycle.

Optional Feature:
- Macro NPC_EXC_EN.
- Defined:
  - Adds inputs exc_req and eret (1 each) and output epc (ADDR_W, reset 0).
  - Priority: exc_req > eret > branch > jump > jr > seq.
  - exc_req: pc<=EXC_VEC, epc<=pc. eret: pc<=epc.
  - Neither touches the RAS. stall blocks both.
  - pc_op reports 00 during exc/eret.
- Undefined: these ports are absent, EXC_VEC is unused, and behaviour is exactly as above.

Test Plan:
- Reset with stall=1 -> pc=0x3000, ras_cnt=0. Then 3 idle clocks -> pc=0x300C.
- pc=0x3010, br_type=001, rs=rt=5, imm16=0xFFFF -> pc_op=01, next pc=0x3010. Same with rs=5, rt=6 -> pc=0x3014.
- pc=0x3000, jal=1, instr_index=0x0000D00 -> pc=0x00003400, ras_cnt=1. Then jr with rs_val=0x3004 -> ras_hit=1, pc=0x3004, ras_cnt=0.
- Five jal with RAS_DEPTH=4 -> ras_cnt stays 4. Four jr pops hit the last four links. A fifth jr -> ras_hit=0, ras_cnt=0.
- stall=1 held 3 cycles with jal=1 -> pc and ras_cnt unchanged. Release stall -> single push.
- NPC_EXC_EN: at pc=0x3020, exc_req=1 -> pc=0x4180, epc=0x3020. Then eret -> pc=0x3020. exc_req together with a taken beq -> pc=0x4180.
